data_array_nway: RTL and testbench

- N-way set-associative cache data store with a per-byte write mask and a registered, one-cycle-latency read that returns all ways of one set in parallel.
- After reset, a built-in clear engine zeroes every line of every way before the array accepts requests.
- Read-after-write forwarding is write-first; the tag and hit logic selects one way from dataout.

---
 rtl/data_array_nway.sv | 136 +++++++++++++
 tb/tb_data_array_nway.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_array_nway.sv
// N-way set-associative cache data store.
// Per-byte write mask, write-first forwarding, one-cycle registered read that
// returns every way of the selected set. A clear engine zeroes all sets after
// reset, and the array accepts requests only once that sweep has finished.

// One way: line storage, write-first read merge and the read-data register.
module data_array_way #(
  parameter int s_index = 3,
  parameter int s_mask  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic [s_index-1:0]    clr_idx_i,
  input  logic [s_mask-1:0]     we_i,
  input  logic [s_index-1:0]    windex_i,
  input  logic [8*s_mask-1:0]   wdata_i,
  input  logic                  re_i,
  input  logic [s_index-1:0]    rindex_i,
  output logic [8*s_mask-1:0]   rdata_o
);
  localparam int s_line   = 8 * s_mask;
  localparam int num_sets = 2 ** s_index;

  logic [s_line-1:0] mem_q [num_sets];
  logic [s_line-1:0] rdata_q, rdata_d;

  // Read data with the same-cycle write to the same set merged in (write-first)
  always_comb begin
    rdata_d = mem_q[rindex_i];
    if (windex_i == rindex_i)
      for (int i = 0; i < s_mask; i++)
        if (we_i[i]) rdata_d[8*i +: 8] = wdata_i[8*i +: 8];
  end

  // Storage: the clear sweep has priority; otherwise apply masked byte writes
  always_ff @(posedge clk) begin
    if (rst) begin
      if (clr_i) mem_q[clr_idx_i] <= '0;
      else
        for (int i = 0; i < s_mask; i++)
          if (we_i[i]) mem_q[windex_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  // Read register: cleared by reset, holds when no read is issued
  always_ff @(posedge clk) begin
    if (!rst)      rdata_q <= '0;
    else if (re_i) rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
endmodule

module data_array_nway #(
  parameter  int s_offset = 5,
  parameter  int s_index  = 3,
  parameter  int num_ways = 2,
  localparam int s_mask   = 2 ** s_offset,
  localparam int s_line   = 8 * s_mask,
  localparam int num_sets = 2 ** s_index,
  localparam int s_way    = (num_ways > 1) ? $clog2(num_ways) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         read,
  input  logic [s_index-1:0]           rindex,
  input  logic [s_mask-1:0]            write_en,
  input  logic [s_way-1:0]             wway,
  input  logic [s_index-1:0]           windex,
  input  logic [s_line-1:0]            datain,
  output logic [num_ways*s_line-1:0]   dataout,
  output logic                         rvalid,
  output logic                         ready
);
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  localparam logic [s_index-1:0] LAST_SET = s_index'(num_sets - 1);

  state_e                 state_q, state_d;
  logic [s_index-1:0]     clr_idx_q, clr_idx_d;
  logic                   rvalid_q;
  logic                   re;
  logic [num_ways-1:0][s_line-1:0] rdata_w;

  // State register, clear pointer and read-valid flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rvalid_q  <= re;
    end
  end

  // Next state: sweep every set once, then open the array for requests
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == LAST_SET) state_d = READY;
    end
  end

  // Outputs decoded from state
  always_comb begin
    ready = (state_q == READY);
    re    = read && (state_q == READY);
  end

  // One instance per way; a wway that matches no instance writes nothing
  for (genvar w = 0; w < num_ways; w++) begin : g_way
    logic [s_mask-1:0] we_w;
    assign we_w = (ready && (wway == s_way'(w))) ? write_en : '0;

    data_array_way #(.s_index(s_index), .s_mask(s_mask)) u_way (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_q == CLEAR),
      .clr_idx_i (clr_idx_q),
      .we_i      (we_w),
      .windex_i  (windex),
      .wdata_i   (datain),
      .re_i      (re),
      .rindex_i  (rindex),
      .rdata_o   (rdata_w[w])
    );
  end

  assign dataout = rdata_w;
  assign rvalid  = rvalid_q;
endmodule

// File: tb/tb_data_array_nway.sv
// Randomized scoreboard bench for data_array_nway against a byte-level model.
module tb_data_array_nway;
  localparam int SO = 5, SI = 3, NW = 2;
  localparam int NB = 2 ** SO, SL = 8 * NB, NS = 2 ** SI;
  localparam int SW = (NW > 1) ? $clog2(NW) : 1;

  logic              clk = 0;
  logic              rst = 0;
  logic              read = 0;
  logic [SI-1:0]     rindex = '0;
  logic [NB-1:0]     write_en = '0;
  logic [SW-1:0]     wway = '0;
  logic [SI-1:0]     windex = '0;
  logic [SL-1:0]     datain = '0;
  logic [NW*SL-1:0]  dataout;
  logic              rvalid, ready;

  data_array_nway #(.s_offset(SO), .s_index(SI), .num_ways(NW)) dut (
    .clk(clk), .rst(rst), .read(read), .rindex(rindex), .write_en(write_en),
    .wway(wway), .windex(windex), .datain(datain), .dataout(dataout),
    .rvalid(rvalid), .ready(ready)
  );

  always #5 clk = ~clk;

  // Reference model: plain byte array plus "cycles since reset release"
  logic [7:0]        mdl [NW][NS][NB];
  bit                m_ready = 0;
  int                clr_cnt = 0;
  bit                exp_rv = 0;
  bit                started = 0;
  logic [NW*SL-1:0]  last_data = '0;
  logic [NW*SL-1:0]  exp_q [$];
  int                total = 0, bad = 0;

  localparam logic [NB-1:0] ALL1 = '1;

  task automatic step(input bit rs, input bit rd, input int ri,
                      input logic [NB-1:0] we, input int ww, input int wi,
                      input logic [SL-1:0] din);
    logic [NW*SL-1:0] e;
    bit pend;
    @(negedge clk);
    rst = rs; read = rd; rindex = ri[SI-1:0]; write_en = we;
    wway = ww[SW-1:0]; windex = wi[SI-1:0]; datain = din;
    pend = 0;
    if (rs && m_ready) begin
      // write-first: commit the write, then take the read snapshot
      if (ww < NW)
        for (int b = 0; b < NB; b++) if (we[b]) mdl[ww][wi][b] = din[8*b +: 8];
      if (rd) begin
        for (int w = 0; w < NW; w++)
          for (int b = 0; b < NB; b++) e[w*SL + 8*b +: 8] = mdl[w][ri][b];
        exp_q.push_back(e);
        pend = 1;
      end
    end
    @(posedge clk);
    exp_rv = pend;
    if (!rs) begin
      m_ready = 0; clr_cnt = 0; exp_rv = 0; last_data = '0; exp_q.delete();
    end else if (!m_ready) begin
      clr_cnt++;
      if (clr_cnt == NS) begin
        m_ready = 1;
        for (int w = 0; w < NW; w++)
          for (int s = 0; s < NS; s++)
            for (int b = 0; b < NB; b++) mdl[w][s][b] = 8'h00;
      end
    end
    started = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic rd_set(input int s);
    step(1, 1, s, '0, 0, 0, '0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, '0);
  endtask

  function automatic logic [SL-1:0] rand_line();
    logic [SL-1:0] l;
    for (int i = 0; i < SL / 32; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Monitor: checks ready/rvalid every cycle, pops expected data on rvalid
  initial begin
    logic [NW*SL-1:0] e;
    forever begin
      @(posedge clk); #1;
      if (started) begin
        total++;
        if (ready !== m_ready) begin
          bad++; $display("FAIL ready: got %b want %b at %0t", ready, m_ready, $time);
        end
        total++;
        if (rvalid !== exp_rv) begin
          bad++; $display("FAIL rvalid: got %b want %b at %0t", rvalid, exp_rv, $time);
        end
        if (rvalid === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL rdata: got rvalid with no expected entry at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            if (dataout !== e) begin
              bad++; $display("FAIL rdata: got %h want %h at %0t", dataout, e, $time);
            end
            last_data = e;
          end
        end else begin
          total++;
          if (dataout !== last_data) begin
            bad++; $display("FAIL hold: got %h want %h at %0t", dataout, last_data, $time);
          end
        end
      end
    end
  end

  initial begin
    logic [SL-1:0] d;
    logic [NB-1:0] m;
    // clear sequence, then every set reads zero
    do_reset(3);
    idle(NS);
    for (int s = 0; s < NS; s++) rd_set(s);
    idle(1);

    // masked write to way 1 set 5
    d = '0; d[31:0] = 32'hDEADBEEF;
    step(1, 0, 0, NB'(32'h0000000F), 1, 5, d);
    rd_set(5);
    idle(1);

    // forwarding: fill set 2 way 0 with 0xAA, then read+partial write same cycle
    d = {NB{8'hAA}};
    step(1, 0, 0, ALL1, 0, 2, d);
    d = '0; d[7:0] = 8'h55;
    step(1, 1, 2, NB'(1), 0, 2, d);
    rd_set(2);

    // hold: one read, then idle cycles keep dataout
    rd_set(3);
    idle(4);

    // requests during clear cycle 2 are ignored
    do_reset(2);
    idle(1);
    step(1, 1, 0, ALL1, 0, 0, rand_line());
    idle(NS - 2);
    rd_set(0);
    idle(1);

    // reset in the middle of the clear sweep restarts it
    do_reset(1);
    idle(5);
    do_reset(1);
    idle(NS);
    for (int s = 0; s < NS; s++) rd_set(s);

    // randomized traffic, biased toward set collisions
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: m = '0;
        1: m = ALL1;
        default: m = NB'($urandom);
      endcase
      step(1, bit'($urandom_range(0, 1)), $urandom_range(0, NS - 1), m,
           $urandom_range(0, (1 << SW) - 1), $urandom_range(0, NS - 1), rand_line());
    end
    idle(2);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
